// File: rtl/kbd_pkg.sv
// Shared constants and types for the memory-mapped PS/2 keyboard peripheral.
package kbd_pkg;

   localparam logic [3:0] KBD_REGION  = 4'h3;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;

   localparam int ST_NOT_EMPTY  = 0;
   localparam int ST_OVERFLOW   = 1;
   localparam int ST_PARITY_ERR = 2;
   localparam int ST_FRAME_ERR  = 3;
   localparam int ST_COUNT_LSB  = 8;

   localparam int CTL_FLUSH     = 0;
   localparam int CTL_CLR_OVF   = 1;
   localparam int CTL_CLR_PAR   = 2;
   localparam int CTL_CLR_FRAME = 3;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge strobe, frame FSM and idle timeout.
// Optional macro KEYBOARD_PARITY_CHECK_EN discards bad-parity frames and pulses parity_err.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data low on strobe)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking stop bit and parity, then emitting or discarding the byte
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]  clk_sync, data_sync;
   logic        clk_prev, strobe, bit_q;
   rx_state_t   state, state_n;
   logic [7:0]  shift, shift_n;
   logic [2:0]  cnt, cnt_n;
   logic        par, par_n, par_ok;
   logic [TW-1:0] tmr, tmr_n;
   logic        valid_n, perr_n, ferr_n, timeout;

`ifdef KEYBOARD_PARITY_CHECK_EN
   assign par_ok = ^{shift, par};
`else
   // parity bit is still captured so the frame timing is unchanged
   logic unused_par;
   assign par_ok     = 1'b1;
   assign unused_par = par;
`endif

   // strobe is registered, so a byte reaches the FIFO 3 cycles after the synchronized edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
         strobe    <= 1'b0;
         bit_q     <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
         strobe    <= clk_prev & ~clk_sync[1];
         bit_q     <= data_sync[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RX_IDLE;
         shift      <= '0;
         cnt        <= '0;
         par        <= 1'b0;
         tmr        <= '0;
         byte_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         shift      <= shift_n;
         cnt        <= cnt_n;
         par        <= par_n;
         tmr        <= tmr_n;
         byte_valid <= valid_n;
         parity_err <= perr_n;
         frame_err  <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      shift_n = shift;
      cnt_n   = cnt;
      par_n   = par;
      tmr_n   = tmr;
      valid_n = 1'b0;
      perr_n  = 1'b0;
      ferr_n  = 1'b0;
      timeout = (state != RX_IDLE) && !strobe && (tmr == '0);

      if (strobe)
         tmr_n = TW'(TIMEOUT_CYCLES - 1);
      else if (state != RX_IDLE && tmr != '0)
         tmr_n = tmr - 1'b1;

      unique case (state)
         RX_IDLE: begin
            if (strobe && !bit_q) begin
               state_n = RX_DATA;
               cnt_n   = '0;
            end
         end
         RX_DATA: begin
            if (strobe) begin
               shift_n = {bit_q, shift[7:1]};
               cnt_n   = cnt + 3'd1;
               if (cnt == 3'd7)
                  state_n = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (strobe) begin
               par_n   = bit_q;
               state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (strobe) begin
               state_n = RX_IDLE;
               if (!bit_q)
                  ferr_n = 1'b1;
               else if (!par_ok)
                  perr_n = 1'b1;
               else
                  valid_n = 1'b1;
            end
         end
         default: state_n = RX_IDLE;
      endcase

      if (timeout)
         state_n = RX_IDLE;
   end

   assign rx_byte = shift;

endmodule

// File: rtl/keyboard_mmio.sv
// Memory-mapped PS/2 keyboard: scancode FIFO, DATA/STATUS/CONTROL registers, 2-cycle read pipeline.
// Parity enforcement is controlled by KEYBOARD_PARITY_CHECK_EN inside ps2_rx.
module keyboard_mmio
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk_cpu_in,
   input  logic        rst_n_in,
   input  logic [31:0] keyboard_addr_in,
   input  logic [31:0] keyboard_data_in,
   input  logic [3:0]  keyboard_write_enable_in,
   output logic [31:0] keyboard_data_out,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic        kbd_irq_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic          rx_valid, rx_perr, rx_ferr;
   logic [7:0]    rx_byte;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   count_ext, status, rd_val, rd_q;
   logic          ovf, perr, ferr;
   logic          sel, wr, pop_req, ctl_wr, flush, full, empty, do_pop, do_push, ovf_set;
   logic [1:0]    offset;
   logic          unused_bits;

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk        (clk_cpu_in),
      .rst_n      (rst_n_in),
      .ps2_clk    (ps2_clk_in),
      .ps2_data   (ps2_data_in),
      .byte_valid (rx_valid),
      .rx_byte    (rx_byte),
      .parity_err (rx_perr),
      .frame_err  (rx_ferr)
   );

   assign sel     = keyboard_addr_in[19:16] == KBD_REGION;
   assign offset  = keyboard_addr_in[3:2];
   assign wr      = sel && (keyboard_write_enable_in != 4'h0);
   assign pop_req = wr && offset == REG_DATA;
   assign ctl_wr  = wr && offset == REG_CONTROL;
   assign flush   = ctl_wr && keyboard_data_in[CTL_FLUSH];
   assign full    = count == CW'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop_req && !empty;
   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_push = rx_valid && (!full || do_pop);
   assign ovf_set = rx_valid && full && !do_pop && !flush;

   assign unused_bits = ^{keyboard_addr_in[31:20], keyboard_addr_in[15:4],
                          keyboard_addr_in[1:0], keyboard_data_in[31:4]};

   always_ff @(posedge clk_cpu_in) begin
      if (do_push && !flush)
         mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge clk_cpu_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk_cpu_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ovf  <= 1'b0;
         perr <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovf  <= ovf_set | (ovf  & ~(ctl_wr & keyboard_data_in[CTL_CLR_OVF]));
         perr <= rx_perr | (perr & ~(ctl_wr & keyboard_data_in[CTL_CLR_PAR]));
         ferr <= rx_ferr | (ferr & ~(ctl_wr & keyboard_data_in[CTL_CLR_FRAME]));
      end
   end

   assign count_ext = 32'(count);

   always_comb begin
      status = '0;
      status[ST_NOT_EMPTY]       = !empty;
      status[ST_OVERFLOW]        = ovf;
      status[ST_PARITY_ERR]      = perr;
      status[ST_FRAME_ERR]       = ferr;
      status[ST_COUNT_LSB +: 8]  = count_ext[7:0];

      rd_val = '0;
      if (sel) begin
         unique case (offset)
            REG_DATA:   rd_val = empty ? 32'h0 : {24'h0, mem[rd_ptr]};
            REG_STATUS: rd_val = status;
            default:    rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk_cpu_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_q              <= '0;
         keyboard_data_out <= '0;
         kbd_irq_out       <= 1'b0;
      end else begin
         rd_q              <= rd_val;
         keyboard_data_out <= rd_q;
         kbd_irq_out       <= !empty;
      end
   end

endmodule

// File: tb/tb_keyboard_mmio.sv
// Self-checking bench for keyboard_mmio: randomized PS/2 frames against a queue-based model.
module tb_keyboard_mmio;

   localparam int DEPTH = 16;
   localparam int TMO   = 400;
   localparam logic [31:0] A_DATA   = 32'h0003_0000;
   localparam logic [31:0] A_STATUS = 32'h0003_0004;
   localparam logic [31:0] A_CTRL   = 32'h0003_0008;
   localparam logic [31:0] A_IDLE   = 32'h0003_000C;
`ifdef KEYBOARD_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = A_IDLE;
   logic [31:0] wdata = '0;
   logic [3:0]  we = '0;
   logic [31:0] rdata;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q[$];
   bit m_ovf, m_perr, m_ferr;

   always #5 clk = ~clk;

   keyboard_mmio #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_cpu_in               (clk),
      .rst_n_in                 (rst_n),
      .keyboard_addr_in         (addr),
      .keyboard_data_in         (wdata),
      .keyboard_write_enable_in (we),
      .keyboard_data_out        (rdata),
      .ps2_clk_in               (ps2_clk),
      .ps2_data_in              (ps2_data),
      .kbd_irq_out              (irq)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] exp_status();
      return {16'h0, 8'(q.size()), 4'h0, m_ferr, m_perr, m_ovf, q.size() != 0};
   endfunction

   function automatic logic [31:0] exp_data();
      if (q.size() == 0) return 32'h0;
      return {24'h0, q[0]};
   endfunction

   function automatic void model_frame(input logic [7:0] b, input bit par_ok, input bit stop);
      if (!stop)                 m_ferr = 1'b1;
      else if (PCHK && !par_ok)  m_perr = 1'b1;
      else if (q.size() == DEPTH) m_ovf = 1'b1;
      else                       q.push_back(b);
   endfunction

   function automatic void model_pop();
      if (q.size() > 0) void'(q.pop_front());
   endfunction

   function automatic void model_ctrl(input logic [31:0] d);
      if (d[0]) q.delete();
      if (d[1]) m_ovf  = 1'b0;
      if (d[2]) m_perr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic ps2_bit(input logic b, input int hp);
      ps2_data = b;
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // returns on the negedge where the stop-bit falling edge is driven
   task automatic ps2_to_stop(input logic [7:0] b, input logic par, input logic stop, output int hp);
      hp = $urandom_range(4, 10);
      ps2_bit(1'b0, hp);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
      ps2_bit(par, hp);
      ps2_data = stop;
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b0;
   endtask

   task automatic ps2_release(input int hp);
      repeat (hp) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      int hp;
      ps2_to_stop(b, par, stop, hp);
      ps2_release(hp);
      repeat (8) @(negedge clk);
      model_frame(b, par == ~^b, stop);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 4'($urandom_range(1, 15));
      @(negedge clk);
      we    = 4'h0;
      addr  = A_IDLE;
      wdata = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d2);
      addr = A_IDLE;
      repeat (2) @(negedge clk);
      addr = a;
      @(negedge clk);
      d1 = rdata;
      @(negedge clk);
      d2 = rdata;
      addr = A_IDLE;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] d1, d2;
      repeat (3) @(negedge clk);
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", rdata); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
      rst_n = 1'b1;
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d2); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== 32'h0) begin n_fail++; $display("FAIL reset_data_empty: got %h want 0", d2); end
   endtask

   task automatic test_basic();
      logic [31:0] d1, d2;
      logic [7:0]  b;
      int hp;
      ps2_to_stop(8'h1C, ~^8'h1C, 1'b1, hp);
      repeat (4) @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL push_latency_early: irq=%b want 0", irq); end
      repeat (2) @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL push_latency_irq: irq=%b want 1", irq); end
      ps2_release(hp);
      model_frame(8'h1C, 1'b1, 1'b1);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL basic_status: got %h want %h", d2, exp_status()); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d1 !== 32'h0) begin n_fail++; $display("FAIL read_latency_n1: got %h want 0", d1); end
      n_checks++;
      if (d2 !== 32'h1C) begin n_fail++; $display("FAIL basic_data: got %h want 0000001c", d2); end
      bus_write(A_DATA, 32'($urandom));
      model_pop();
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== 32'h0) begin n_fail++; $display("FAIL basic_pop_status: got %h want 0", d2); end
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send_frame(b, ~^b, 1'b1);
         bus_read(A_DATA, d1, d2);
         n_checks++;
         if (d2 !== exp_data()) begin n_fail++; $display("FAIL random_data[%0d]: got %h want %h", i, d2, exp_data()); end
         if ($urandom_range(0, 1) == 1) begin
            bus_write(A_DATA, 32'hFFFF_FFFF);
            model_pop();
         end
         bus_read(A_STATUS, d1, d2);
         n_checks++;
         if (d2 !== exp_status()) begin n_fail++; $display("FAIL random_status[%0d]: got %h want %h", i, d2, exp_status()); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d1, d2;
      logic [7:0]  b;
      bus_write(A_CTRL, 32'hF);
      model_ctrl(32'hF);
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         send_frame(b, ~^b, 1'b1);
      end
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status() || d2[15:8] !== 8'd16 || d2[1] !== 1'b1) begin
         n_fail++; $display("FAIL overflow_status: got %h want %h", d2, exp_status());
      end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== exp_data()) begin n_fail++; $display("FAIL overflow_head: got %h want %h", d2, exp_data()); end
      bus_write(A_CTRL, 32'h2);
      model_ctrl(32'h2);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL overflow_clear: got %h want %h", d2, exp_status()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d1, d2;
      logic [7:0]  b;
      int hp;
      b = 8'($urandom);
      ps2_to_stop(b, ~^b, 1'b1, hp);
      repeat (4) @(negedge clk);
      addr  = A_DATA;
      wdata = 32'($urandom);
      we    = 4'h1;
      @(negedge clk);
      we    = 4'h0;
      addr  = A_IDLE;
      model_pop();
      model_frame(b, 1'b1, 1'b1);
      ps2_release(hp);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL full_push_pop_status: got %h want %h", d2, exp_status()); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== exp_data()) begin n_fail++; $display("FAIL full_push_pop_head: got %h want %h", d2, exp_data()); end
      @(negedge clk);
      addr  = A_CTRL;
      wdata = 32'h1;
      we    = 4'h8;
      @(negedge clk);
      we    = 4'h0;
      addr  = A_IDLE;
      model_ctrl(32'h1);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL flush_irq_lag: irq=%b want 1", irq); end
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL flush_irq_clear: irq=%b want 0", irq); end
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL flush_status: got %h want %h", d2, exp_status()); end
   endtask

   task automatic test_parity();
      logic [31:0] d1, d2;
      send_frame(8'h5A, ^8'h5A, 1'b1);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL parity_status: got %h want %h", d2, exp_status()); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== exp_data()) begin n_fail++; $display("FAIL parity_data: got %h want %h", d2, exp_data()); end
      bus_write(A_CTRL, 32'hF);
      model_ctrl(32'hF);
   endtask

   task automatic test_frame_err();
      logic [31:0] d1, d2;
      logic [7:0]  b;
      b = 8'($urandom);
      send_frame(b, ~^b, 1'b0);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL frame_err_status: got %h want %h", d2, exp_status()); end
      bus_write(A_CTRL, 32'h8);
      model_ctrl(32'h8);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL frame_err_clear: got %h want %h", d2, exp_status()); end
   endtask

   task automatic test_timeout();
      logic [31:0] d1, d2;
      int hp;
      hp = $urandom_range(4, 10);
      ps2_bit(1'b0, hp);
      for (int i = 0; i < 3; i++) ps2_bit(1'($urandom), hp);
      ps2_data = 1'b1;
      repeat (TMO + 20) @(negedge clk);
      send_frame(8'h29, ~^8'h29, 1'b1);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL timeout_status: got %h want %h", d2, exp_status()); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== 32'h29) begin n_fail++; $display("FAIL timeout_data: got %h want 00000029", d2); end
   endtask

   task automatic test_addr();
      logic [31:0] d1, d2;
      logic [7:0]  b;
      b = 8'($urandom);
      send_frame(b, ~^b, 1'b1);
      bus_write(32'h0002_0004, 32'hF);
      bus_write(32'h0002_0000, 32'h0);
      bus_write(32'h0002_0008, 32'hF);
      bus_write(A_IDLE, 32'hF);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL addr_unselected_status: got %h want %h", d2, exp_status()); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== exp_data()) begin n_fail++; $display("FAIL addr_unselected_data: got %h want %h", d2, exp_data()); end
      bus_read(A_CTRL, d1, d2);
      n_checks++;
      if (d2 !== 32'h0) begin n_fail++; $display("FAIL control_reads_zero: got %h want 0", d2); end
      bus_read(32'h0002_0004, d1, d2);
      n_checks++;
      if (d2 !== 32'h0) begin n_fail++; $display("FAIL unselected_read: got %h want 0", d2); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d1, d2;
      logic [7:0]  b;
      int hp;
      hp = $urandom_range(4, 10);
      ps2_bit(1'b0, hp);
      for (int i = 0; i < 3; i++) ps2_bit(1'($urandom), hp);
      addr = A_STATUS;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      m_ovf = 0; m_perr = 0; m_ferr = 0;
      @(negedge clk);
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_data_out: got %h want 0", rdata); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b want 0", irq); end
      addr     = A_IDLE;
      ps2_data = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      b = 8'($urandom);
      send_frame(b, ~^b, 1'b1);
      bus_read(A_STATUS, d1, d2);
      n_checks++;
      if (d2 !== exp_status()) begin n_fail++; $display("FAIL midreset_status: got %h want %h", d2, exp_status()); end
      bus_read(A_DATA, d1, d2);
      n_checks++;
      if (d2 !== exp_data()) begin n_fail++; $display("FAIL midreset_rx: got %h want %h", d2, exp_data()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_parity();
      test_frame_err();
      test_timeout();
      test_addr();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
